// File: rtl/onewire_slave_rx_crc.sv
// 1-Wire slave receiver: detects the master reset pulse, answers with a presence pulse,
// then shifts in an LSB-first frame whose trailing byte is checked as a Dallas CRC-8.
module onewire_slave_rx_crc #(
  parameter int CLK_FREQ_HZ  = 1_000_000,
  parameter int FRAME_BITS   = 64,
  parameter int SAMPLE_US    = 15,
  parameter int RESET_MIN_US = 480,
  parameter int PRES_WAIT_US = 30,
  parameter int PRES_US      = 120,
  parameter int CRC_EN       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_dq,
  output logic                  o_dq_oe,
  output logic [FRAME_BITS-9:0] o_data,
  output logic [7:0]            o_crc,
  output logic                  o_valid,
  output logic                  o_error,
  output logic                  o_busy
);

  localparam int CYC_US        = CLK_FREQ_HZ / 1_000_000;
  localparam int RESET_CYC     = RESET_MIN_US * CYC_US;
  localparam int PRES_WAIT_CYC = PRES_WAIT_US * CYC_US;
  localparam int PRES_CYC      = PRES_US * CYC_US;
  localparam int SAMPLE_CYC    = SAMPLE_US * CYC_US;
  localparam int PAYLOAD_BITS  = FRAME_BITS - 8;
  localparam bit CRC_CHECK     = (CRC_EN != 0);

  localparam int MAX_A   = (RESET_CYC > PRES_CYC) ? RESET_CYC : PRES_CYC;
  localparam int MAX_B   = (PRES_WAIT_CYC > SAMPLE_CYC) ? PRES_WAIT_CYC : SAMPLE_CYC;
  localparam int TMR_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int BW      = $clog2(FRAME_BITS + 1);

  typedef enum logic [3:0] {
    IDLE, RST_LOW, PRES_WAIT, PRES_DRV, PRES_REL, WAIT_FALL, SLOT, WAIT_HIGH, DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  dq_meta_q, dq_s;
  logic [TW-1:0]         tmr_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [7:0]            crc_q;
  logic [FRAME_BITS-1:0] sr_q;
  logic                  dq_oe_q, valid_q, error_q, busy_q;
  logic [FRAME_BITS-9:0] data_q;
  logic [7:0]            crc_out_q;

  logic       tmr_clr, tmr_one, frame_init, sample_en, done_go, abort;
  logic       reset_seen, crc_fb;
  logic [7:0] crc_next;

  // The first low cycle is spent leaving IDLE/WAIT_FALL, so the low time seen is tmr+1.
  assign reset_seen = (tmr_q >= TW'(RESET_CYC - 1));
  assign crc_fb     = crc_q[0] ^ dq_s;
  assign crc_next   = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);

  // NOTE: every output of a combinational block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    tmr_clr    = 1'b0;
    tmr_one    = 1'b0;
    frame_init = 1'b0;
    sample_en  = 1'b0;
    done_go    = 1'b0;
    abort      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!dq_s) begin
          state_d = RST_LOW;
          tmr_clr = 1'b1;
        end
      end
      RST_LOW: begin
        if (dq_s) begin
          if (reset_seen) begin
            state_d = PRES_WAIT;
            tmr_one = 1'b1;  // the release-detect cycle counts toward the wait
          end else begin
            state_d = IDLE;
          end
        end
      end
      PRES_WAIT: begin
        if (tmr_q >= TW'(PRES_WAIT_CYC - 1)) begin
          state_d = PRES_DRV;
          tmr_clr = 1'b1;
        end
      end
      PRES_DRV: begin
        if (tmr_q == TW'(PRES_CYC - 1)) state_d = PRES_REL;
      end
      PRES_REL: begin
        if (dq_s) begin
          state_d    = WAIT_FALL;
          frame_init = 1'b1;
        end
      end
      WAIT_FALL: begin
        if (!dq_s) begin
          state_d = SLOT;
          tmr_clr = 1'b1;
        end
      end
      SLOT: begin
        if (!dq_s && reset_seen) begin
          state_d = RST_LOW;
          abort   = 1'b1;
        end else if (tmr_q == TW'(SAMPLE_CYC - 1)) begin
          state_d   = WAIT_HIGH;
          sample_en = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (dq_s) begin
          if (bit_cnt_q == BW'(FRAME_BITS)) begin
            state_d = DONE;
            done_go = 1'b1;
          end else begin
            state_d = WAIT_FALL;
          end
        end else if (reset_seen) begin
          // A slot stretched into a reset pulse: drop the frame and treat it as a reset.
          state_d = RST_LOW;
          abort   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dq_meta_q <= 1'b1;  // released bus reads high
      dq_s      <= 1'b1;
      state_q   <= IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      crc_q     <= '0;
      sr_q      <= '0;
      dq_oe_q   <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      crc_out_q <= '0;
    end else begin
      dq_meta_q <= i_dq;
      dq_s      <= dq_meta_q;
      state_q   <= state_d;

      if (tmr_clr)             tmr_q <= '0;
      else if (tmr_one)        tmr_q <= TW'(1);
      else if (tmr_q != '1)    tmr_q <= tmr_q + TW'(1);

      if (frame_init) begin
        bit_cnt_q <= '0;
        crc_q     <= '0;
      end else if (sample_en) begin
        sr_q      <= {dq_s, sr_q[FRAME_BITS-1:1]};
        bit_cnt_q <= bit_cnt_q + BW'(1);
        if (bit_cnt_q < BW'(PAYLOAD_BITS)) crc_q <= crc_next;
      end

      if (done_go) begin
        data_q    <= sr_q[FRAME_BITS-9:0];
        crc_out_q <= sr_q[FRAME_BITS-1:FRAME_BITS-8];
      end

      valid_q <= done_go;
      error_q <= abort | (done_go & CRC_CHECK & (crc_q != sr_q[FRAME_BITS-1:FRAME_BITS-8]));
      dq_oe_q <= (state_d == PRES_DRV);
      busy_q  <= (state_d inside {PRES_DRV, PRES_REL, WAIT_FALL, SLOT, WAIT_HIGH});
    end
  end

  assign o_dq_oe = dq_oe_q;
  assign o_data  = data_q;
  assign o_crc   = crc_out_q;
  assign o_valid = valid_q;
  assign o_error = error_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_onewire_slave_rx_crc.sv
// Bench for onewire_slave_rx_crc: a bus master drives reset pulses and frames on a wired-AND
// DQ line shared by a CRC-checking and a non-checking slave; a monitor scores every output pulse.
module tb_onewire_slave_rx_crc;

  localparam int US = 1000;  // ticks per microsecond = one clock period

  localparam logic [63:0] FRAME_A   = 64'hA200_0000_01B8_1C02;
  localparam logic [63:0] FRAME_B   = 64'hA300_0000_01B8_1C02;
  localparam logic [55:0] PAYLOAD_A = 56'h00_0000_01B8_1C02;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [55:0] data;
    logic [7:0]  crc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic master_low = 1'b0;
  logic dq;

  logic        oe0, valid0, error0, busy0;
  logic [55:0] data0;
  logic [7:0]  crc0;
  logic        oe1, valid1, error1, busy1;
  logic [55:0] data1;
  logic [7:0]  crc1;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  always #(US/2) clk = ~clk;

  assign dq = ~(master_low | oe0 | oe1);

  onewire_slave_rx_crc #(.CRC_EN(1)) u_dut0 (
    .clk(clk), .reset(reset), .i_dq(dq), .o_dq_oe(oe0), .o_data(data0),
    .o_crc(crc0), .o_valid(valid0), .o_error(error0), .o_busy(busy0)
  );

  onewire_slave_rx_crc #(.CRC_EN(0)) u_dut1 (
    .clk(clk), .reset(reset), .i_dq(dq), .o_dq_oe(oe1), .o_data(data1),
    .o_crc(crc1), .o_valid(valid1), .o_error(error1), .o_busy(busy1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && (valid0 || error0)) begin
      if (sb0.size() == 0) begin
        check("dut0_spurious_pulse", 64'({valid0, error0}), 64'd0);
      end else begin
        e = sb0.pop_front();
        check("dut0_valid", 64'(valid0), 64'(e.valid));
        check("dut0_error", 64'(error0), 64'(e.err));
        check("dut0_data",  64'(data0),  64'(e.data));
        check("dut0_crc",   64'(crc0),   64'(e.crc));
      end
    end
    if (reset && (valid1 || error1)) begin
      if (sb1.size() == 0) begin
        check("dut1_spurious_pulse", 64'({valid1, error1}), 64'd0);
      end else begin
        e = sb1.pop_front();
        check("dut1_valid", 64'(valid1), 64'(e.valid));
        check("dut1_error", 64'(error1), 64'(e.err));
        check("dut1_data",  64'(data1),  64'(e.data));
        check("dut1_crc",   64'(crc1),   64'(e.crc));
      end
    end
  end

  task automatic expect_pulse(input logic valid, input logic err0, input logic err1,
                              input logic [55:0] data, input logic [7:0] crc);
    sb0.push_back({valid, err0, data, crc});
    sb1.push_back({valid, err1, data, crc});
  endtask

  task automatic wait_us(input int n);
    #(n * US);
  endtask

  task automatic bus_low(input int low_us, input int high_us);
    master_low = 1'b1;
    wait_us(low_us);
    master_low = 1'b0;
    wait_us(high_us);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (v[i]) bus_low(6, 64);
      else      bus_low(60, 10);
    end
  endtask

  // Called right after the master releases the bus; stimulus sits 200 ticks past a falling
  // clock edge, so the k-th sample below is k cycles after release.
  task automatic measure_presence(input string tag);
    int first0 = -1;
    int width0 = 0;
    int width1 = 0;
    for (int k = 1; k <= 220; k++) begin
      @(negedge clk);
      if (oe0) begin
        if (first0 < 0) first0 = k;
        width0++;
      end
      if (oe1) width1++;
    end
    check({tag, "_pres_start"},  64'(first0), 64'd32);
    check({tag, "_pres_width0"}, 64'(width0), 64'd120);
    check({tag, "_pres_width1"}, 64'(width1), 64'd120);
    #200;
  endtask

  task automatic reset_pulse_and_presence(input string tag);
    master_low = 1'b1;
    wait_us(480);
    master_low = 1'b0;
    measure_presence(tag);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_pending0"}, 64'(sb0.size()), 64'd0);
    check({tag, "_pending1"}, 64'(sb1.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_oe"},    64'(oe0),    64'd0);
    check({tag, "_busy"},  64'(busy0),  64'd0);
    check({tag, "_valid"}, 64'(valid0), 64'd0);
    check({tag, "_error"}, 64'(error0), 64'd0);
    check({tag, "_data"},  64'(data0),  64'd0);
    check({tag, "_crc"},   64'(crc0),   64'd0);
  endtask

  initial begin : stimulus
    int quiet;
    #(2 * US + 100);
    check_outputs_zero("por");
    @(negedge clk);
    #200;
    reset = 1'b1;
    wait_us(5);

    // Reset pulse of exactly the minimum length, then a frame with a good CRC.
    reset_pulse_and_presence("t1");
    expect_pulse(1'b1, 1'b0, 1'b0, PAYLOAD_A, 8'hA2);
    send_bits(FRAME_A, 64);
    check_drained("t2");
    check("t2_busy_after", 64'(busy0), 64'd0);

    // Corrupted CRC byte: error on the checking slave only.
    reset_pulse_and_presence("t3");
    expect_pulse(1'b1, 1'b1, 1'b0, PAYLOAD_A, 8'hA3);
    send_bits(FRAME_B, 64);
    check_drained("t3");

    // Too short for a reset pulse: no presence, no busy, no pulses.
    master_low = 1'b1;
    wait_us(200);
    master_low = 1'b0;
    quiet = 0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (oe0 || busy0 || oe1 || busy1) quiet++;
    end
    #200;
    check("t4_no_presence", 64'(quiet), 64'd0);

    // Abort after 20 bits by holding DQ low for 500us; previous frame outputs must persist.
    reset_pulse_and_presence("t5a");
    expect_pulse(1'b0, 1'b1, 1'b1, PAYLOAD_A, 8'hA3);
    send_bits(FRAME_A, 20);
    master_low = 1'b1;
    wait_us(500);
    master_low = 1'b0;
    check_drained("t5");
    measure_presence("t5b");
    check("t5_data_kept", 64'(data0), 64'(PAYLOAD_A));

    // Asynchronous reset in the low phase of bit 30.
    send_bits(FRAME_A, 29);
    master_low = 1'b1;
    wait_us(3);
    check("t6_busy_mid", 64'(busy0), 64'd1);
    reset = 1'b0;
    #1;
    check_outputs_zero("t6_rst");
    #(57 * US - 1);
    master_low = 1'b0;
    wait_us(10);
    reset = 1'b1;
    wait_us(5);
    reset_pulse_and_presence("t6");
    expect_pulse(1'b1, 1'b0, 1'b0, PAYLOAD_A, 8'hA2);
    send_bits(FRAME_A, 64);
    check_drained("t6");

    wait_us(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
